deflate_stream_packer: RTL and testbench

//  Downstream stage of the deflate image compressor. Captures the compressed byte

---
 rtl/deflate_stream_packer.sv | 196 +++++++++++++++++++
 tb/tb_deflate_stream_packer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/deflate_stream_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : deflate_stream_packer                                        |
// | Description : Buffers the compressed byte stream of the deflate core and   |
// |               replays it as a framed valid/ready byte stream: a 4-byte     |
// |               little-endian length prefix followed by the payload.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module deflate_stream_packer #(
    parameter int DEPTH  = 16384,
    parameter int ADDR_W = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_vld,
    input  logic [31:0] in_size,
    input  logic        in_done,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        busy,
    output logic        frame_done,
    output logic        overflow,
    output logic        mismatch
);

    localparam logic [1:0]        c_st_idle    = 2'd0;
    localparam logic [1:0]        c_st_capture = 2'd1;
    localparam logic [1:0]        c_st_header  = 2'd2;
    localparam logic [1:0]        c_st_payload = 2'd3;
    localparam logic [ADDR_W:0]   c_depth      = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_ptr_one    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   c_ptr_zero   = '0;

    logic [7:0]      r_mem [DEPTH];
    logic [1:0]      r_state;
    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_rd_ptr;
    logic [ADDR_W:0] r_out_cnt;
    logic [ADDR_W:0] r_len;
    logic [31:0]     r_rx_count;
    logic [2:0]      r_hdr_idx;
    logic            r_pf_valid;
    logic [7:0]      r_rd_data;
    logic [7:0]      r_m_data;
    logic            r_m_valid;
    logic            r_m_last;
    logic            r_frame_done;
    logic            r_overflow;
    logic            r_mismatch;

    logic [1:0]      w_state_nxt;
    logic            w_hs;
    logic            w_slot_free;
    logic            w_cap_wr;
    logic            w_cap_drop;
    logic            w_hdr_load;
    logic            w_pay_load;
    logic            w_rd_en;
    logic            w_end;
    logic [31:0]     w_len32;
    logic [7:0]      w_hdr_byte;
    logic [ADDR_W:0] w_wr_ptr_nxt;
    logic [31:0]     w_rx_nxt;

    // Next-state and per-cycle control decode
    always_comb begin
        w_state_nxt = r_state;
        w_hs        = r_m_valid && m_ready;
        w_slot_free = !r_m_valid || m_ready;
        w_cap_wr    = 1'b0;
        w_cap_drop  = 1'b0;
        w_hdr_load  = 1'b0;
        w_pay_load  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start) w_state_nxt = c_st_capture;
            end
            c_st_capture: begin
                w_cap_wr   = in_vld && (r_wr_ptr < c_depth);
                w_cap_drop = in_vld && (r_wr_ptr >= c_depth);
                if (in_done) w_state_nxt = c_st_header;
            end
            c_st_header: begin
                // index 4 means all prefix bytes are loaded (only reached when len==0)
                w_hdr_load = w_slot_free && (r_hdr_idx != 3'd4);
                if (w_hdr_load && (r_hdr_idx == 3'd3) && (r_len != c_ptr_zero))
                    w_state_nxt = c_st_payload;
            end
            c_st_payload: begin
                w_pay_load = w_slot_free && (r_out_cnt < r_len) && r_pf_valid;
            end
            default: w_state_nxt = c_st_idle;
        endcase
        w_end = w_hs && r_m_last;
        if (w_end) w_state_nxt = c_st_idle;
        // keep one payload byte fetched ahead so the output never bubbles
        w_rd_en = ((r_state == c_st_header) || (r_state == c_st_payload)) &&
                  (r_rd_ptr < r_len) && (!r_pf_valid || w_pay_load);
    end

    // Data-path helpers: prefix byte select and capture-side increments
    always_comb begin
        w_len32      = 32'(r_len);
        w_hdr_byte   = w_len32[8*r_hdr_idx[1:0] +: 8];
        w_wr_ptr_nxt = r_wr_ptr + (w_cap_wr ? c_ptr_one : c_ptr_zero);
        w_rx_nxt     = r_rx_count + (in_vld ? 32'd1 : 32'd0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= c_st_idle;
        else      r_state <= w_state_nxt;
    end

    // Pointers, counters, flags and the output holding register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_out_cnt    <= '0;
            r_len        <= '0;
            r_rx_count   <= '0;
            r_hdr_idx    <= '0;
            r_pf_valid   <= 1'b0;
            r_m_data     <= '0;
            r_m_valid    <= 1'b0;
            r_m_last     <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_mismatch   <= 1'b0;
        end else begin
            r_frame_done <= w_end;
            if ((r_state == c_st_idle) && start) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_out_cnt  <= '0;
                r_len      <= '0;
                r_rx_count <= '0;
                r_hdr_idx  <= '0;
                r_pf_valid <= 1'b0;
                r_overflow <= 1'b0;
                r_mismatch <= 1'b0;
            end
            if (r_state == c_st_capture) begin
                r_wr_ptr   <= w_wr_ptr_nxt;
                r_rx_count <= w_rx_nxt;
                if (w_cap_drop) r_overflow <= 1'b1;
                // a byte arriving with in_done is already folded into the next values
                if (in_done) begin
                    r_len <= w_wr_ptr_nxt;
                    if (in_size != w_rx_nxt) r_mismatch <= 1'b1;
                end
            end
            if (w_hdr_load) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_hdr_byte;
                r_m_last  <= (r_hdr_idx == 3'd3) && (r_len == c_ptr_zero);
                r_hdr_idx <= r_hdr_idx + 3'd1;
            end else if (w_pay_load) begin
                r_m_valid <= 1'b1;
                r_m_data  <= r_rd_data;
                r_m_last  <= ((r_out_cnt + c_ptr_one) == r_len);
                r_out_cnt <= r_out_cnt + c_ptr_one;
            end else if (w_hs) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end
            if (w_rd_en) begin
                r_rd_ptr   <= r_rd_ptr + c_ptr_one;
                r_pf_valid <= 1'b1;
            end else if (w_pay_load) begin
                r_pf_valid <= 1'b0;
            end
        end
    end

    // Payload buffer: capture writes, synchronous prefetch read
    always_ff @(posedge clk) begin
        if (w_cap_wr) r_mem[r_wr_ptr[ADDR_W-1:0]] <= in_data;
        if (w_rd_en)  r_rd_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
    end

    assign m_data     = r_m_data;
    assign m_valid    = r_m_valid;
    assign m_last     = r_m_last;
    assign busy       = (r_state != c_st_idle);
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign mismatch   = r_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_deflate_stream_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_deflate_stream_packer                                     |
// | Description : Randomised self-checking bench for deflate_stream_packer     |
// |               using a queue-based model of the framed output stream.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_deflate_stream_packer;

    localparam int DEPTH  = 16384;
    localparam int ADDR_W = 14;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_vld = 1'b0;
    logic [31:0] in_size = '0;
    logic        in_done = 1'b0;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;
    logic        busy;
    logic        frame_done;
    logic        overflow;
    logic        mismatch;

    int total = 0;
    int bad   = 0;
    int ready_mode = 0;

    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       got_last_q[$];

    deflate_stream_packer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_vld(in_vld),
        .in_size(in_size), .in_done(in_done), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .busy(busy), .frame_done(frame_done),
        .overflow(overflow), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Downstream ready pattern: 0 always ready, 1 toggling, 2 random
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output checker: handshakes against the model queue, stall stability, frame_done
    logic       stall_prev = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;
    logic       fd_pending = 1'b0;
    always @(negedge clk) begin
        logic       fd_exp;
        logic [7:0] e;
        if (!rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
            fd_pending = 1'b0;
        end else begin
            fd_exp = fd_pending;
            fd_pending = 1'b0;
            chk("frame_done", 32'(frame_done), 32'(fd_exp));
            if (stall_prev) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data", 32'(m_data), 32'(prev_data));
                chk("stall_last", 32'(m_last), 32'(prev_last));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_byte", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_data", 32'(m_data), 32'(e));
                    chk("m_last", 32'(m_last), 32'(exp_q.size() == 0));
                    got_q.push_back(m_data);
                    got_last_q.push_back(m_last);
                    if (exp_q.size() == 0) fd_pending = 1'b1;
                end
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    // Drive one frame from tx_q; model the framed stream and the sticky flags
    task automatic run_frame(input logic [31:0] size, input bit done_with_last,
                             input bit gaps, input bit wait_end);
        int n;
        int stored;
        int budget;
        bit seen;
        n = tx_q.size();
        stored = (n > DEPTH) ? DEPTH : n;
        got_q.delete();
        got_last_q.delete();
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(stored >> (8 * k)));
        for (int i = 0; i < stored; i++) exp_q.push_back(tx_q[i]);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_capture", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 9) < 3)) begin
                start = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 2)) tick();
                start = 1'b0;
            end
            in_vld  = 1'b1;
            in_data = tx_q[i];
            if (done_with_last && (i == n - 1)) begin
                in_done = 1'b1;
                in_size = size;
            end
            tick();
            in_vld  = 1'b0;
            in_done = 1'b0;
        end
        if (!done_with_last || (n == 0)) begin
            in_done = 1'b1;
            in_size = size;
            tick();
            in_done = 1'b0;
        end
        if (wait_end) begin
            budget = 4 * (stored + 8) + 100;
            seen = 1'b0;
            for (int c = 0; c < budget && !seen; c++) begin
                tick();
                if (frame_done) seen = 1'b1;
            end
            chk("frame_end_seen", 32'(seen), 32'd1);
            tick();
            chk("overflow", 32'(overflow), 32'(n > DEPTH));
            chk("mismatch", 32'(mismatch), 32'(size != 32'(n)));
            chk("all_bytes_out", 32'(exp_q.size()), 32'd0);
            chk("busy_idle", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] lit7[7];
        logic [7:0] lit4[4];
        bit reached;
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_mismatch", 32'(mismatch), 32'd0);

        // Three bytes, always ready: literal stream
        ready_mode = 0;
        tx_q = '{8'hA1, 8'hB2, 8'hC3};
        run_frame(32'd3, 1'b0, 1'b0, 1'b1);
        lit7 = '{8'h03, 8'h00, 8'h00, 8'h00, 8'hA1, 8'hB2, 8'hC3};
        chk("lit3_count", 32'(got_q.size()), 32'd7);
        for (int i = 0; i < 7 && i < got_q.size(); i++) chk("lit3_byte", 32'(got_q[i]), 32'(lit7[i]));
        if (got_q.size() == 7) begin
            chk("lit3_last_c3", 32'(got_last_q[6]), 32'd1);
            chk("lit3_notlast_b2", 32'(got_last_q[5]), 32'd0);
        end

        // Five bytes with toggling ready
        ready_mode = 1;
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_frame(32'd5, 1'b0, 1'b0, 1'b1);
        chk("toggle_count", 32'(got_q.size()), 32'd9);

        // Empty frame: only the zero prefix, last on the 4th byte
        ready_mode = 0;
        tx_q.delete();
        run_frame(32'd0, 1'b0, 1'b0, 1'b1);
        lit4 = '{8'h00, 8'h00, 8'h00, 8'h00};
        chk("zero_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) chk("zero_byte", 32'(got_q[i]), 32'(lit4[i]));
        if (got_q.size() == 4) chk("zero_last", 32'(got_last_q[3]), 32'd1);

        // Size disagreement: 4 bytes, in_size=5
        ready_mode = 2;
        tx_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_frame(32'd5, 1'b0, 1'b0, 1'b1);
        chk("mm_flag", 32'(mismatch), 32'd1);

        // Final byte together with in_done
        ready_mode = 2;
        tx_q = '{8'h5A, 8'h6B, 8'h7C};
        run_frame(32'd3, 1'b1, 1'b0, 1'b1);
        chk("same_cycle_count", 32'(got_q.size()), 32'd7);
        if (got_q.size() == 7) chk("same_cycle_tail", 32'(got_q[6]), 32'h7C);

        // Buffer overflow: DEPTH+2 bytes
        ready_mode = 0;
        tx_q.delete();
        for (int i = 0; i < DEPTH + 2; i++) tx_q.push_back(8'($urandom));
        run_frame(32'(DEPTH + 2), 1'b0, 1'b0, 1'b1);
        chk("ovf_count", 32'(got_q.size()), 32'(DEPTH + 4));
        if (got_q.size() >= 4) begin
            chk("ovf_len0", 32'(got_q[0]), 32'h00);
            chk("ovf_len1", 32'(got_q[1]), 32'h40);
            chk("ovf_len2", 32'(got_q[2]), 32'h00);
        end

        // Reset in the middle of the payload, then a clean frame
        ready_mode = 0;
        tx_q.delete();
        for (int i = 0; i < 20; i++) tx_q.push_back(8'($urandom));
        run_frame(32'd20, 1'b0, 1'b0, 1'b0);
        reached = 1'b0;
        for (int c = 0; c < 200 && !reached; c++) begin
            tick();
            if (got_q.size() >= 8) reached = 1'b1;
        end
        chk("mid_payload_reached", 32'(reached), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_frame(32'd6, 1'b0, 1'b0, 1'b1);
        chk("fresh_count", 32'(got_q.size()), 32'd10);

        // Randomised frames
        for (int f = 0; f < 8; f++) begin
            int n;
            logic [31:0] sz;
            n = $urandom_range(0, 40);
            tx_q.delete();
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
            sz = ($urandom_range(0, 3) == 0) ? 32'(n + $urandom_range(1, 3)) : 32'(n);
            ready_mode = $urandom_range(0, 2);
            run_frame(sz, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
